tdm_demux4: RTL

Receive-side time-division demultiplexer for the DE10-Lite lab designs: recovers four single-bit channels from one serial slot stream carrying a frame-sync marker, and presents them as held, registered outputs suitable for driving LEDR. It is the far end of a 4:1 TDM mux link, which carries SW bits over one wire. It contains a slot counter, a lock state machine with flywheel tolerance of missed sync markers, and a shadow register so that outputs change only on complete frames.

---
 rtl/tdm_demux4.sv | 118 +++++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// Receive-side 4-slot TDM demultiplexer with frame-sync lock tracking.
// Outputs change only on complete frames and hold between them.
module tdm_demux4 #(
    parameter int unsigned MISS_MAX = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       din,
    input  logic       frame_sync,
    output logic [3:0] y,
    output logic       frame_valid,
    output logic       locked,
    output logic       sync_err
);

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    localparam logic [3:0] MISS_LIM = 4'(MISS_MAX);

    state_t     state_q, state_d;
    logic [1:0] slot_q, slot_d;
    logic [3:0] miss_cnt_q, miss_cnt_d;
    logic [2:0] shadow_q, shadow_d;
    logic [3:0] y_q, y_d;
    logic       frame_valid_q, frame_valid_d;
    logic       sync_err_q, sync_err_d;
    logic [3:0] miss_inc;

    assign miss_inc = miss_cnt_q + 4'd1;

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        miss_cnt_d    = miss_cnt_q;
        shadow_d      = shadow_q;
        y_d           = y_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (tick) begin
            unique case (state_q)
                HUNT: begin
                    if (frame_sync) begin
                        shadow_d[0] = din;
                        slot_d      = 2'd1;
                        miss_cnt_d  = 4'd0;
                        state_d     = LOCKED;
                    end
                end
                LOCKED: begin
                    if (slot_q == 2'd0) begin
                        if (frame_sync) begin
                            shadow_d[0] = din;
                            slot_d      = 2'd1;
                            miss_cnt_d  = 4'd0;
                        end else if (miss_inc >= MISS_LIM) begin
                            // Too many missed markers: drop lock, keep y.
                            state_d    = HUNT;
                            slot_d     = 2'd0;
                            miss_cnt_d = 4'd0;
                        end else begin
                            shadow_d[0] = din;
                            slot_d      = 2'd1;
                            miss_cnt_d  = miss_inc;
                        end
                    end else if (frame_sync) begin
                        // Misplaced marker restarts the frame on this tick.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = din;
                        slot_d      = 2'd1;
                        miss_cnt_d  = 4'd0;
                    end else begin
                        unique case (slot_q)
                            2'd1: shadow_d[1] = din;
                            2'd2: shadow_d[2] = din;
                            default: begin
                                y_d           = {din, shadow_q};
                                frame_valid_d = 1'b1;
                            end
                        endcase
                        slot_d = slot_q + 2'd1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            miss_cnt_q    <= 4'd0;
            shadow_q      <= 3'd0;
            y_q           <= 4'd0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            miss_cnt_q    <= miss_cnt_d;
            shadow_q      <= shadow_d;
            y_q           <= y_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign y           = y_q;
    assign frame_valid = frame_valid_q;
    assign sync_err    = sync_err_q;
    assign locked      = (state_q == LOCKED);

endmodule
